// File: rtl/mem_seq_ctrl_if.sv
// mem_seq_ctrl_if: direct-access and playback bus for mem_seq_ctrl.
// master = board-side driver of strobes/data, slave = the memory/sequencer.
interface mem_seq_ctrl_if #(
   parameter int WIDTH  = 8,
   parameter int ADDR_W = 4
);
   logic              we;
   logic              re;
   logic [ADDR_W-1:0] addr;
   logic [WIDTH-1:0]  din;
   logic              start;
   logic [ADDR_W-1:0] last;
   logic              tick;
   logic [WIDTH-1:0]  dout;
   logic              dvalid;
   logic              busy;
   logic              done;

   modport master (
      output we, re, addr, din, start, last, tick,
      input  dout, dvalid, busy, done
   );

   modport slave (
      input  we, re, addr, din, start, last, tick,
      output dout, dvalid, busy, done
   );
endinterface

// File: rtl/mem_seq_ctrl.sv
// mem_seq_ctrl: single-port synchronous memory (DEPTH = 2**ADDR_W words of
// WIDTH bits) with registered read, a one-cycle valid flag, and a playback
// sequencer that streams words 0..LAST, one per TICK cycle.
// Optional build macro MEM_SEQ_CLR_MEM_EN: after reset the memory is swept
// to zero (BUSY high for DEPTH cycles) before direct access is accepted.
module mem_seq_ctrl #(
   parameter int WIDTH  = 8,
   parameter int ADDR_W = 4
) (
   input  logic           i_clk,
   input  logic           i_clr,
   mem_seq_ctrl_if.slave  io_bus
);

   localparam int DEPTH = 2**ADDR_W;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
`ifdef MEM_SEQ_CLR_MEM_EN
      ST_CLEAR = 2'd2,
`endif
      ST_PLAY  = 2'd1
   } state_t;

   state_t            r_state;
   logic [ADDR_W-1:0] r_ptr;
   logic [ADDR_W-1:0] r_last;
   logic [WIDTH-1:0]  r_dout;
   logic              r_dvalid;
   logic              r_done;
   logic              r_busy;
   logic [WIDTH-1:0]  r_mem [DEPTH];

   state_t            w_state_nxt;
   logic [ADDR_W-1:0] w_ptr_nxt;
   logic [ADDR_W-1:0] w_last_nxt;
   logic              w_dvalid_nxt;
   logic              w_done_nxt;
   logic              w_busy_nxt;
   logic              w_rd_en;
   logic [ADDR_W-1:0] w_rd_addr;
   logic              w_mem_we;
   logic [ADDR_W-1:0] w_mem_addr;
   logic [WIDTH-1:0]  w_mem_wdata;

   // Next-state, memory strobes and next output values
   always_comb begin
      w_state_nxt  = r_state;
      w_ptr_nxt    = r_ptr;
      w_last_nxt   = r_last;
      w_dvalid_nxt = 1'b0;
      w_done_nxt   = 1'b0;
      w_busy_nxt   = 1'b0;
      w_rd_en      = 1'b0;
      w_rd_addr    = r_ptr;
      w_mem_we     = 1'b0;
      w_mem_addr   = io_bus.addr;
      w_mem_wdata  = io_bus.din;

      case (r_state)
         ST_IDLE: begin
            // r_busy can still be high for the one cycle after a clear sweep
            if (!r_busy) begin
               w_mem_we = io_bus.we;
               // START in the DONE cycle is ignored; START beats RE
               if (io_bus.start && !r_done) begin
                  w_state_nxt = ST_PLAY;
                  w_last_nxt  = io_bus.last;
                  w_ptr_nxt   = {ADDR_W{1'b0}};
                  w_busy_nxt  = 1'b1;
               end else if (io_bus.re) begin
                  w_rd_en      = 1'b1;
                  w_rd_addr    = io_bus.addr;
                  w_dvalid_nxt = 1'b1;
               end else begin
                  w_rd_en = 1'b0;
               end
            end else begin
               w_mem_we = 1'b0;
            end
         end

         ST_PLAY: begin
            w_busy_nxt = 1'b1;
            if (io_bus.tick) begin
               w_rd_en      = 1'b1;
               w_rd_addr    = r_ptr;
               w_dvalid_nxt = 1'b1;
               // final word: DONE, DVALID and BUSY low all land together
               if (r_ptr == r_last) begin
                  w_state_nxt = ST_IDLE;
                  w_ptr_nxt   = {ADDR_W{1'b0}};
                  w_done_nxt  = 1'b1;
                  w_busy_nxt  = 1'b0;
               end else begin
                  w_ptr_nxt = r_ptr + ADDR_W'(1);
               end
            end else begin
               w_rd_en = 1'b0;
            end
         end

`ifdef MEM_SEQ_CLR_MEM_EN
         ST_CLEAR: begin
            w_busy_nxt  = 1'b1;
            w_mem_we    = 1'b1;
            w_mem_addr  = r_ptr;
            w_mem_wdata = {WIDTH{1'b0}};
            if (r_ptr == {ADDR_W{1'b1}}) begin
               w_state_nxt = ST_IDLE;
               w_ptr_nxt   = {ADDR_W{1'b0}};
            end else begin
               w_ptr_nxt = r_ptr + ADDR_W'(1);
            end
         end
`endif

         default: begin
            w_state_nxt = ST_IDLE;
            w_ptr_nxt   = {ADDR_W{1'b0}};
         end
      endcase
   end

   // State, pointer and registered outputs; CLR overrides everything
   always_ff @(posedge i_clk) begin
      if (i_clr) begin
`ifdef MEM_SEQ_CLR_MEM_EN
         r_state <= ST_CLEAR;
`else
         r_state <= ST_IDLE;
`endif
         r_ptr    <= {ADDR_W{1'b0}};
         r_last   <= {ADDR_W{1'b0}};
         r_dout   <= {WIDTH{1'b0}};
         r_dvalid <= 1'b0;
         r_done   <= 1'b0;
         r_busy   <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_ptr    <= w_ptr_nxt;
         r_last   <= w_last_nxt;
         r_dvalid <= w_dvalid_nxt;
         r_done   <= w_done_nxt;
         r_busy   <= w_busy_nxt;
         if (w_rd_en) begin
            r_dout <= r_mem[w_rd_addr];
         end else begin
            r_dout <= r_dout;
         end
      end
   end

   // Memory array, no reset so it infers as block or distributed RAM
   always_ff @(posedge i_clk) begin
      if (w_mem_we && !i_clr) begin
         r_mem[w_mem_addr] <= w_mem_wdata;
      end
   end

   assign io_bus.dout   = r_dout;
   assign io_bus.dvalid = r_dvalid;
   assign io_bus.busy   = r_busy;
   assign io_bus.done   = r_done;

endmodule
